// File: rtl/loader_pkg.sv
// Shared types and codes for the program loader frame parser.
package loader_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN,
    S_DATA,
    S_CSUM
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/program_load_ctrl_if.sv
// Byte stream in, memory write port and CPU control/status out.
interface program_load_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic                  cpu_hold;
    logic [ADDR_WIDTH-1:0] run_addr;
    logic                  run_start;
    logic                  busy;
    logic                  frame_ok;
    logic                  frame_err;
    logic [1:0]            err_code;

    // master: UART side feeding bytes and observing the loader
    modport master (
        output rx_data, rx_valid,
        input  mem_addr, mem_wdata, mem_we, cpu_hold, run_addr, run_start,
               busy, frame_ok, frame_err, err_code
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_addr, mem_wdata, mem_we, cpu_hold, run_addr, run_start,
               busy, frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/loader_timeout.sv
// Inter-byte idle watchdog: expire pulses on the TIMEOUT_CYCLES-th idle clock.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1250000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // A byte in the expiry cycle (clear) suppresses the pulse
    assign expire = enable && !clear && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear || !enable || expire)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/program_load_ctrl.sv
// Frame parser/sequencer: validates loader frames, writes payload to program
// memory, and holds/releases the target CPU.
module program_load_ctrl
    import loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1250000
) (
    input  logic               clock,
    input  logic               reset_n,
    program_load_ctrl_if.slave bus
);
    state_t                state_q, state_d;
    logic [7:0]            csum_q, csum_d, csum_add;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            len_q, len_d;
    logic                  is_run_q, is_run_d;
    logic [15:0]           addr_full;
    logic                  expire;

    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic [ADDR_WIDTH-1:0] run_addr_q, run_addr_d;
    logic                  run_start_q, run_start_d;
    logic                  busy_q, busy_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;

    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (bus.rx_valid),
        .enable (state_q != S_HUNT),
        .expire (expire)
    );

    assign csum_add  = csum_q + bus.rx_data;
    assign addr_full = {hi_q, bus.rx_data};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_HUNT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        csum_d      = csum_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        len_d       = len_q;
        is_run_d    = is_run_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        cpu_hold_d  = cpu_hold_q;
        run_addr_d  = run_addr_q;
        run_start_d = 1'b0;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = ERR_NONE;

        if (bus.rx_valid) begin
            csum_d = csum_add;
            unique case (state_q)
                S_HUNT: begin
                    csum_d = '0;
                    if (bus.rx_data == SYNC_BYTE) state_d = S_CMD;
                end
                S_CMD: begin
                    if (bus.rx_data == CMD_WRITE) begin
                        is_run_d   = 1'b0;
                        cpu_hold_d = 1'b1;
                        state_d    = S_ADDR_HI;
                    end else if (bus.rx_data == CMD_RUN) begin
                        is_run_d = 1'b1;
                        state_d  = S_ADDR_HI;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CMD;
                        state_d = S_HUNT;
                    end
                end
                S_ADDR_HI: begin
                    hi_d    = bus.rx_data;
                    state_d = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d  = addr_full[ADDR_WIDTH-1:0];
                    state_d = S_LEN;
                end
                S_LEN: begin
                    // LEN of zero encodes a full 256-byte payload
                    len_d   = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                    state_d = is_run_q ? S_CSUM : S_DATA;
                end
                S_DATA: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.rx_data;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    len_d       = len_q - 9'd1;
                    if (len_q == 9'd1) state_d = S_CSUM;
                end
                S_CSUM: begin
                    state_d = S_HUNT;
                    if (csum_add == 8'd0) begin
                        ok_d = 1'b1;
                        if (is_run_q) begin
                            run_addr_d  = addr_q;
                            run_start_d = 1'b1;
                            cpu_hold_d  = 1'b0;
                        end
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end else if (expire) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = S_HUNT;
        end

        busy_d = (state_d != S_HUNT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            csum_q      <= '0;
            hi_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            is_run_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_hold_q  <= 1'b1;
            run_addr_q  <= '0;
            run_start_q <= 1'b0;
            busy_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            csum_q      <= csum_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            is_run_q    <= is_run_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_hold_q  <= cpu_hold_d;
            run_addr_q  <= run_addr_d;
            run_start_q <= run_start_d;
            busy_q      <= busy_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.run_addr  = run_addr_q;
    assign bus.run_start = run_start_q;
    assign bus.busy      = busy_q;
    assign bus.frame_ok  = ok_q;
    assign bus.frame_err = err_q;
    assign bus.err_code  = code_q;
endmodule

// File: tb/tb_program_load_ctrl.sv
// Frame-level reference model driving directed and random loader frames.
module tb_program_load_ctrl;
    localparam int AW = 16;
    localparam int TO = 50;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    program_load_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    program_load_ctrl #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    logic        hold_m;
    logic [15:0] run_addr_m;
    logic [7:0]  pay_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input bit we, input logic [15:0] a,
                               input logic [7:0] d, input bit ok, input bit err,
                               input logic [1:0] code, input bit start, input bit busy);
        chk({tag, ".we"}, bus.mem_we, we);
        if (we) begin
            chk({tag, ".addr"}, bus.mem_addr, a);
            chk({tag, ".wdata"}, bus.mem_wdata, d);
        end
        chk({tag, ".ok"}, bus.frame_ok, ok);
        chk({tag, ".err"}, bus.frame_err, err);
        if (err) chk({tag, ".code"}, bus.err_code, code);
        chk({tag, ".start"}, bus.run_start, start);
        chk({tag, ".busy"}, bus.busy, busy);
        chk({tag, ".hold"}, bus.cpu_hold, hold_m);
        chk({tag, ".run_addr"}, bus.run_addr, run_addr_m);
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) begin
            @(negedge clock);
            chk("gap.pulses", {bus.mem_we, bus.frame_ok, bus.frame_err, bus.run_start}, 4'b0);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".we"}, bus.mem_we, 0);
        chk({tag, ".addr"}, bus.mem_addr, 0);
        chk({tag, ".wdata"}, bus.mem_wdata, 0);
        chk({tag, ".hold"}, bus.cpu_hold, 1);
        chk({tag, ".run_addr"}, bus.run_addr, 0);
        chk({tag, ".start"}, bus.run_start, 0);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".ok"}, bus.frame_ok, 0);
        chk({tag, ".err"}, bus.frame_err, 0);
        chk({tag, ".code"}, bus.err_code, 0);
    endtask

    // Whole frame: expectations derived from frame contents, payload from pay_q
    task automatic do_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len,
                            input bit bad, input int max_gap);
        logic [7:0]  sum, csum;
        logic [15:0] wa;
        int n;
        bit is_w, is_r;
        is_w = (cmd == 8'h01);
        is_r = (cmd == 8'h02);
        send(8'hA5);
        expect_resp("sync", 0, 0, 0, 0, 0, 0, 0, 1);
        gap(max_gap);
        send(cmd);
        if (!is_w && !is_r) begin
            expect_resp("badcmd", 0, 0, 0, 0, 1, 2'd1, 0, 0);
            return;
        end
        if (is_w) hold_m = 1'b1;
        expect_resp("cmd", 0, 0, 0, 0, 0, 0, 0, 1);
        gap(max_gap); send(addr[15:8]); expect_resp("ahi", 0, 0, 0, 0, 0, 0, 0, 1);
        gap(max_gap); send(addr[7:0]);  expect_resp("alo", 0, 0, 0, 0, 0, 0, 0, 1);
        gap(max_gap); send(len);        expect_resp("len", 0, 0, 0, 0, 0, 0, 0, 1);
        sum = cmd + addr[15:8] + addr[7:0] + len;
        if (is_w) begin
            n = (len == 8'd0) ? 256 : int'(len);
            for (int k = 0; k < n; k++) begin
                gap(max_gap);
                send(pay_q[k]);
                sum = sum + pay_q[k];
                wa = addr + 16'(k);
                expect_resp("data", 1, wa, pay_q[k], 0, 0, 0, 0, 1);
            end
        end
        csum = 8'd0 - sum;
        if (bad) csum = csum + 8'($urandom_range(1, 255));
        gap(max_gap);
        send(csum);
        if (!bad) begin
            if (is_r) begin
                hold_m = 1'b0;
                run_addr_m = addr;
            end
            expect_resp("csum_ok", 0, 0, 0, 1, 0, 0, is_r, 0);
        end else begin
            expect_resp("csum_bad", 0, 0, 0, 0, 1, 2'd2, 0, 0);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1 chk_reset(tag);
        hold_m = 1'b1;
        run_addr_m = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] c, b, len;
        int r;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        hold_m = 1'b1;
        run_addr_m = '0;
        repeat (3) @(negedge clock);
        chk_reset("reset");
        reset_n = 1'b1;
        @(negedge clock);

        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        do_frame(8'h01, 16'h1234, 8'h03, 0, 0);
        do_frame(8'h02, 16'h0100, 8'h00, 0, 0);
        chk("t2.hold_low", bus.cpu_hold, 0);
        do_frame(8'h01, 16'h1234, 8'h03, 1, 0);
        do_frame(8'h07, 16'h0000, 8'h00, 0, 0);
        pay_q = '{8'h11, 8'h22};
        do_frame(8'h01, 16'hFFFF, 8'h02, 0, 1);

        // Timeout fires on the TO-th idle clock after the last byte
        send(8'hA5); send(8'h01); hold_m = 1'b1; send(8'h00); send(8'h00);
        repeat (TO - 1) @(negedge clock);
        chk("to.before.err", bus.frame_err, 0);
        chk("to.before.busy", bus.busy, 1);
        @(negedge clock);
        expect_resp("to.fire", 0, 0, 0, 0, 1, 2'd3, 0, 0);
        @(negedge clock);
        chk("to.after.err", bus.frame_err, 0);

        // Byte landing in the expiry cycle wins
        send(8'hA5); send(8'h01); send(8'h00); send(8'h00);
        repeat (TO - 1) @(negedge clock);
        send(8'h01);
        expect_resp("to.edge.len", 0, 0, 0, 0, 0, 0, 0, 1);
        send(8'h5A);
        expect_resp("to.edge.data", 1, 16'h0000, 8'h5A, 0, 0, 0, 0, 1);
        send(8'hA4);
        expect_resp("to.edge.csum", 0, 0, 0, 1, 0, 0, 0, 0);

        // Reset mid-frame with CPU released, then mid-DATA
        do_frame(8'h02, 16'hBEEF, 8'h33, 0, 2);
        send(8'hA5); send(8'h02); send(8'h12);
        async_reset("rst.run");
        send(8'hA5); send(8'h01); send(8'h40); send(8'h00); send(8'h04);
        send(8'h77); send(8'h88);
        async_reset("rst.data");
        send(8'h00);
        expect_resp("junk00", 0, 0, 0, 0, 0, 0, 0, 0);
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_frame(8'h01, 16'h4000, 8'h04, 0, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                send(b);
                expect_resp("junk", 0, 0, 0, 0, 0, 0, 0, 0);
            end
            r = $urandom_range(0, 19);
            if (r < 11) c = 8'h01;
            else if (r < 16) c = 8'h02;
            else begin
                c = 8'($urandom);
                if (c == 8'h01 || c == 8'h02) c = 8'h80;
            end
            len = (i == 7) ? 8'd0 : 8'($urandom_range(1, 6));
            pay_q.delete();
            for (int k = 0; k < 256; k++)
                pay_q.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
            do_frame(c, 16'($urandom), len, ($urandom_range(0, 3) == 0), 3);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
